// File: rtl/uart_rx_sampler_if.sv
// Receive-side handshake bundle: one-entry byte buffer, valid/ack, sticky error flags.
// Parity signals exist only when UART_RX_PARITY_EN is defined.
interface uart_rx_sampler_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ack;
    logic                 framing_err;
    logic                 overrun_err;
    logic                 err_clear;
`ifdef UART_RX_PARITY_EN
    logic                 parity_odd;
    logic                 parity_err;

    modport master (
        output rx_data, rx_valid, framing_err, overrun_err, parity_err,
        input  rx_ack, err_clear, parity_odd
    );
    modport slave (
        input  rx_data, rx_valid, framing_err, overrun_err, parity_err,
        output rx_ack, err_clear, parity_odd
    );
`else
    modport master (
        output rx_data, rx_valid, framing_err, overrun_err,
        input  rx_ack, err_clear
    );
    modport slave (
        input  rx_data, rx_valid, framing_err, overrun_err,
        output rx_ack, err_clear
    );
`endif
endinterface

// File: rtl/uart_rx_sampler.sv
// UART 8N1 receiver: 2-flop sync, mid-bit sampling, one-entry buffer, sticky framing/overrun flags.
// Latency: rx_valid rises 2 sync + 9.5 bit periods + 1 delivery cycle after the start edge.
// Backpressure: none on the line; full buffer without rx_ack drops the byte. Optional parity: UART_RX_PARITY_EN.
module uart_rx_sampler #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             rxd,
    output logic             busy,
    uart_rx_sampler_if.master rx
);
    localparam int TW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] T_HALF = TW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [TW-1:0] T_FULL = TW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_RX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t               state, state_nxt;
    logic [TW-1:0]        timer, timer_nxt;
    logic [BW-1:0]        bit_idx;
    logic [DATA_BITS-1:0] shreg;
    logic                 sync1, rxd_s;
    logic                 armed;
    logic                 tick, shift_en, stop_smp;
    logic                 dlv_vld, dlv_fe;
    logic [DATA_BITS-1:0] dlv_dat;
`ifdef UART_RX_PARITY_EN
    logic                 par_smp, par_bad, dlv_pe;
`endif

    assign tick = (timer == '0);
    assign busy = (state != S_IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync1 <= 1'b1;
            rxd_s <= 1'b1;
        end else begin
            sync1 <= rxd;
            rxd_s <= sync1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        shift_en  = 1'b0;
        stop_smp  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_smp   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (armed && !rxd_s) begin
                    state_nxt = S_START;
                    timer_nxt = T_HALF;
                end
            end
            S_START: begin
                if (tick) begin
                    timer_nxt = T_FULL;
                    state_nxt = rxd_s ? S_IDLE : S_DATA;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            S_DATA: begin
                if (tick) begin
                    timer_nxt = T_FULL;
                    shift_en  = 1'b1;
                    if (bit_idx == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = S_PARITY;
`else
                        state_nxt = S_STOP;
`endif
                    end
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (tick) begin
                    timer_nxt = T_FULL;
                    par_smp   = 1'b1;
                    state_nxt = S_STOP;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
`endif
            S_STOP: begin
                // Leave at mid-stop so a back-to-back start edge is not missed.
                if (tick) begin
                    timer_nxt = T_FULL;
                    stop_smp  = 1'b1;
                    state_nxt = S_IDLE;
                end else begin
                    timer_nxt = timer - 1'b1;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_idx <= '0;
            shreg   <= '0;
            armed   <= 1'b1;
            dlv_vld <= 1'b0;
            dlv_fe  <= 1'b0;
            dlv_dat <= '0;
        end else begin
            if (state == S_START && tick)
                bit_idx <= '0;
            else if (shift_en)
                bit_idx <= bit_idx + 1'b1;
            if (shift_en)
                shreg <= {rxd_s, shreg[DATA_BITS-1:1]};
            // A low stop (break) disarms until the line is seen idle again.
            if (stop_smp)
                armed <= rxd_s;
            else if (state == S_IDLE && rxd_s)
                armed <= 1'b1;
            dlv_vld <= stop_smp;
            if (stop_smp) begin
                dlv_dat <= shreg;
                dlv_fe  <= !rxd_s;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            par_bad <= 1'b0;
            dlv_pe  <= 1'b0;
        end else begin
            if (par_smp)
                par_bad <= ((^shreg) ^ rxd_s) != rx.parity_odd;
            if (stop_smp)
                dlv_pe <= par_bad;
        end
    end
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rx.rx_data     <= '0;
            rx.rx_valid    <= 1'b0;
            rx.framing_err <= 1'b0;
            rx.overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            rx.parity_err  <= 1'b0;
`endif
        end else begin
            if (dlv_vld && (!rx.rx_valid || rx.rx_ack)) begin
                rx.rx_data  <= dlv_dat;
                rx.rx_valid <= 1'b1;
            end else if (rx.rx_ack) begin
                rx.rx_valid <= 1'b0;
            end
            // New errors take priority over a simultaneous err_clear.
            rx.framing_err <= (rx.framing_err && !rx.err_clear) || (dlv_vld && dlv_fe);
            rx.overrun_err <= (rx.overrun_err && !rx.err_clear) ||
                              (dlv_vld && rx.rx_valid && !rx.rx_ack);
`ifdef UART_RX_PARITY_EN
            rx.parity_err  <= (rx.parity_err && !rx.err_clear) || (dlv_vld && dlv_pe);
`endif
        end
    end
endmodule

// File: doc/uart_rx_sampler.md
Name: uart_rx_sampler

Overview:
- UART receiver: the receive-direction partner of the project's UART transmitter (TXD path).
- Recovers 8N1 frames from the asynchronous `rxd` pin using a clock-count bit timer and mid-bit sampling.
- Holds each received byte in a one-entry buffer with valid/ack handshake.
- Flags framing and overrun errors for the SpinalHDL UART core's command/status logic.

Parameters:
- CLKS_PER_BIT, 16, clk cycles per bit period; even, >= 4
- DATA_BITS, 8, data bits per frame (LSB first), 5..8

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- rxd  input  1  raw serial line, idle high, asynchronous to clk
- rx_data  output  DATA_BITS  received byte, stable while rx_valid=1
- rx_valid  output  1  buffer holds an unconsumed byte
- rx_ack  input  1  consumer takes rx_data; clears rx_valid
- framing_err  output  1  sticky: a stop bit was sampled low
- overrun_err  output  1  sticky: a byte arrived while the buffer was full
- err_clear  input  1  clears both sticky flags
- busy  output  1  FSM not in IDLE

Behaviour:
- Interface: one clock (`clk`); reset is asynchronous and active-low (`resetn`).
- Reset values:
  - rx_data=0, rx_valid=0, framing_err=0, overrun_err=0, busy=0.
  - Synchronizer flops = 1; FSM = IDLE.
- Synchronizer: 2-flop synchronizer on rxd, producing rxd_s. All logic uses rxd_s only.
- FSM states: IDLE, START, DATA, STOP (PARITY only when the optional feature is compiled in).
- IDLE: the first cycle with rxd_s=0 (call it cycle T) moves to START and loads the bit timer to count CLKS_PER_BIT/2.
- START: at T+CLKS_PER_BIT/2, sample rxd_s.
  - 1 = false start (glitch): return to IDLE, no flags.
  - 0 = go to DATA, bit index=0.
- DATA: data bit i is sampled at T+CLKS_PER_BIT/2+(i+1)*CLKS_PER_BIT and shifted in LSB first. After bit DATA_BITS-1, go to STOP.
- STOP: sampled one bit period after the last data bit.
  - Return to IDLE in the same cycle (mid-stop), so back-to-back frames are accepted.
  - If the sample is 0, set framing_err. The byte is still delivered.
- Delivery: the cycle after the stop sample, the byte is offered to the buffer.
  - Buffer empty, or rx_ack=1 in the delivery cycle: load rx_data, rx_valid=1.
  - Buffer full and rx_ack=0: new byte dropped, old rx_data kept, overrun_err set.
- rx_ack with rx_valid=1 and no delivery: rx_valid=0 next cycle. rx_ack while empty is ignored.
- err_clear in the same cycle as a new error: the error wins (flag stays set).
- Break (rxd held low): frame completes with framing_err=1 and data=0. The FSM then waits in IDLE for rxd_s to return to 1 before arming again. No new start is accepted on a continuous low.
- busy=1 in every non-IDLE state.
- Reset mid-frame: everything returns to reset values immediately. No partial byte is delivered.
- Bit timer: width $clog2(CLKS_PER_BIT). It wraps from 0 to CLKS_PER_BIT-1 at each sample point.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- When defined:
  - Adds the PARITY state between DATA and STOP, sampled one bit period after the last data bit (STOP sample shifts one bit later).
  - Adds input parity_odd (1=odd, 0=even) and output parity_err (sticky, cleared by err_clear).
  - On a mismatch, parity_err is set and the byte is still delivered.
- When undefined: 8N1 only; parity_odd and parity_err do not exist.

Test Plan (CLKS_PER_BIT=16):
- Send 0x55, then 0xA3, with 8N1 timing, rx_ack pulsed after each → rx_data=0x55 then 0xA3, rx_valid rises 2+9.5*16+1 cycles (±1) after the rxd fall, no error flags.
- Pulse rxd low for 5 clk → busy pulses briefly, no rx_valid, FSM returns to IDLE, no flags.
- Send 0x3C with the stop bit forced 0 → rx_data=0x3C, rx_valid=1, framing_err=1; err_clear → framing_err=0.
- Send 0x11 then 0x22 back-to-back with no rx_ack → rx_data=0x11, overrun_err=1. Repeat with rx_ack asserted exactly in the second delivery cycle → rx_data=0x22, rx_valid=1, no overrun.
- Assert resetn=0 during data bit 4 of a frame, then release and send 0x7E → no byte from the aborted frame, next rx_data=0x7E.
- (UART_RX_PARITY_EN) Send 0x01 with even parity configured and a parity bit of 0 → parity_err=1, rx_data=0x01. Send with a parity bit of 1 → no error.
